// File: rtl/serial_port_pkg.sv
// serial_port_pkg: shared state encoding, parity modes and parameter checks for the serial receive path
package serial_port_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_WAIT_IDLE = 3'd6;
  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_START = S_START,
    ST_DATA = S_DATA,
    ST_PARITY = S_PARITY,
    ST_STOP = S_STOP,
    ST_DONE = S_DONE,
    ST_WAIT_IDLE = S_WAIT_IDLE
  } state_t;
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD = 2'd2;
  function automatic bit data_bits_ok(input int n);
    return n >= 5 && n <= 9;
  endfunction
endpackage

// File: rtl/serial_port_rx_sampler.sv
// serial_port_rx_sampler: rx synchroniser, oversample tick counter and 3-sample majority vote
module serial_port_rx_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  input logic baud_tick,
  input logic rx,
  input logic run,
  output logic rx_s,
  output logic decide,
  output logic wrap,
  output logic bit_v
);
  localparam int TW = $clog2(OVERSAMPLE);
  logic [SYNC_STAGES-1:0] sync;
  logic [TW-1:0] tick_cnt;
  logic s0, s1;
  assign rx_s = sync[SYNC_STAGES-1];
  assign decide = run && baud_tick && tick_cnt == TW'(OVERSAMPLE / 2 + 1);
  assign wrap = run && baud_tick && tick_cnt == TW'(OVERSAMPLE - 1);
  assign bit_v = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '1;
      tick_cnt <= '0;
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
      if (!run) tick_cnt <= '0;
      else if (baud_tick) tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
      if (baud_tick && tick_cnt == TW'(OVERSAMPLE / 2 - 1)) s0 <= rx_s;
      if (baud_tick && tick_cnt == TW'(OVERSAMPLE / 2)) s1 <= rx_s;
    end
  end
endmodule

// File: rtl/serial_port_rx_os.sv
// serial_port_rx_os: oversampling UART receiver FSM with parity, framing and break reporting
module serial_port_rx_os
  import serial_port_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int OVERSAMPLE = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  input logic baud_tick,
  input logic [1:0] parity_mode,
  input logic rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic rx_dv,
  output logic rx_parity_err,
  output logic rx_frame_err,
  output logic rx_break,
  output logic busy
);
  localparam int CW = $clog2(DATA_BITS);
  if (!data_bits_ok(DATA_BITS)) begin : g_bad_data_bits
    $error("serial_port_rx_os: DATA_BITS must be 5..9");
  end
  state_t state, state_nx;
  logic rx_s, decide, wrap, bit_v, run, start_ok, last_stop;
  logic [CW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0] pmode;
  logic par_err, frame_acc, zero_acc;
  assign run = state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
  assign start_ok = state == ST_START && decide && !bit_v;
  assign last_stop = state == ST_STOP && decide && bit_cnt == CW'(STOP_BITS - 1);
  assign rx_dv = state == ST_DONE;
  assign busy = state != ST_IDLE;
  serial_port_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .clk(clk),
    .rst_n(rst_n),
    .baud_tick(baud_tick),
    .rx(rx),
    .run(run),
    .rx_s(rx_s),
    .decide(decide),
    .wrap(wrap),
    .bit_v(bit_v)
  );
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = baud_tick && !rx_s ? ST_START : ST_IDLE;
      ST_START: state_nx = decide && bit_v ? ST_IDLE : wrap ? ST_DATA : ST_START;
      ST_DATA:
        if (wrap && bit_cnt == CW'(DATA_BITS - 1))
          state_nx = pmode == PAR_EVEN || pmode == PAR_ODD ? ST_PARITY : ST_STOP;
      ST_PARITY: state_nx = wrap ? ST_STOP : ST_PARITY;
      ST_STOP: state_nx = last_stop ? ST_DONE : ST_STOP;
      ST_DONE: state_nx = rx_frame_err ? ST_WAIT_IDLE : ST_IDLE;
      ST_WAIT_IDLE: state_nx = baud_tick && rx_s ? ST_IDLE : ST_WAIT_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      pmode <= PAR_NONE;
      par_err <= 1'b0;
      frame_acc <= 1'b0;
      zero_acc <= 1'b0;
      rx_data <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_break <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        pmode <= parity_mode;
        shreg <= '0;
        par_err <= 1'b0;
        frame_acc <= 1'b0;
        zero_acc <= 1'b1;
      end
      if (wrap)
        bit_cnt <= (state == ST_DATA && bit_cnt != CW'(DATA_BITS - 1)) || state == ST_STOP ?
                   bit_cnt + 1'b1 : '0;
      if (decide && state == ST_DATA) shreg[bit_cnt] <= bit_v;
      if (decide && state == ST_PARITY) par_err <= ^shreg ^ bit_v ^ (pmode == PAR_ODD);
      // any 1 in data, parity or the first stop bit rules out a break
      if (decide && bit_v && (state == ST_DATA || state == ST_PARITY || (state == ST_STOP && bit_cnt == '0)))
        zero_acc <= 1'b0;
      if (decide && state == ST_STOP && !bit_v) frame_acc <= 1'b1;
      if (last_stop) begin
        rx_data <= shreg;
        rx_parity_err <= par_err;
        rx_frame_err <= frame_acc | ~bit_v;
        rx_break <= zero_acc & (bit_cnt != '0 | ~bit_v);
      end
    end
  end
endmodule

// File: doc/serial_port_rx_os.md
Name: serial_port_rx_os

Overview:
- Parametrised, oversampling UART receiver. Next generation of the serial-port receive path.
- Adds configurable data width, runtime parity, 1 or 2 stop bits, majority-vote sampling, a line synchroniser, false-start rejection, and framing/parity/break reporting.
- Sits between the pad `rx` line and the RX FIFO. Driven by a shared baud generator tick at OVERSAMPLE x baud rate.

Parameters:
- DATA_BITS, 8: data bits per frame, legal 5..9.
- STOP_BITS, 1: stop bits checked, legal 1 or 2.
- OVERSAMPLE, 16: baud_tick pulses per bit, even, legal 8..32.
- SYNC_STAGES, 2: metastability flops on rx, legal 2..3.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low; clock clk.
- baud_tick  in  1  single-cycle pulse at OVERSAMPLE x baud.
- parity_mode  in  2  0=none, 1=even, 2=odd, 3=reserved (treated as none). Latched at start-bit confirm.
- rx  in  1  asynchronous serial line, idle high.
- rx_data  out  DATA_BITS  received word, LSB = first bit on the line.
- rx_dv  out  1  one-cycle valid strobe.
- rx_parity_err  out  1  qualified by rx_dv.
- rx_frame_err  out  1  qualified by rx_dv.
- rx_break  out  1  qualified by rx_dv.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - Synchroniser flops reset to 1.
  - rx_data=0, rx_dv=0, all error flags=0, busy=0, state=IDLE, counters=0.
  - Reset mid-frame aborts the frame with no rx_dv.
- Advancement:
  - All sampling advances only on cycles with baud_tick=1.
  - tick_cnt counts 0..OVERSAMPLE-1, then wraps.
- Sampling:
  - Bit value = majority of the synchronised rx at tick_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The decision is made at OVERSAMPLE/2+1.
- States: IDLE, START, DATA, PARITY, STOP, DONE, WAIT_IDLE.
  - IDLE: on baud_tick with synchronised rx=0, go to START with tick_cnt=0.
  - START:
    - At the decision point, majority 1 = false start; return to IDLE with no output.
    - Majority 0: latch parity_mode, clear the shift register.
    - At tick_cnt wrap, go to DATA, bit_cnt=0.
  - DATA:
    - Each decision writes bit bit_cnt of the shift register.
    - Wrap with bit_cnt=DATA_BITS-1 goes to PARITY if the latched mode is even or odd, else to STOP.
    - Otherwise bit_cnt increments.
  - PARITY:
    - Sample the parity bit.
    - Even: error if XOR(data, parity bit) = 1.
    - Odd: error if XOR(data, parity bit) = 0.
    - Wrap goes to STOP.
  - STOP:
    - Sample each stop bit; any 0 sets frame_err.
    - After the decision point of the last stop bit, go to DONE immediately (no wait for wrap), so a back-to-back start bit is not missed.
  - DONE, one clk cycle:
    - rx_data <= shift register; rx_dv=1; flags driven.
    - If frame_err=1, go to WAIT_IDLE; else go to IDLE.
  - WAIT_IDLE: stay until a baud_tick sees synchronised rx=1, then go to IDLE. This prevents retriggering inside a held break.
- Break: rx_break=1 when all data bits are 0, the parity bit (if enabled) is 0, and the first stop bit is 0. Break implies frame_err=1.
- Flags and rx_data hold their values between strobes. They update only in DONE.
- Latency: rx_dv rises exactly 1 clk after the final stop-bit decision.
- parity_mode changes mid-frame have no effect on the current frame.

Decomposition:
- Package serial_port_pkg holds:
  - state encoding localparams
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD
  - a DATA_BITS range check
- Sub-module serial_port_rx_sampler owns the SYNC_STAGES synchroniser, the 3-sample majority vote, tick_cnt and the decision strobe. The top module is the FSM plus the shift/parity datapath.

Test Plan:
1. Defaults, parity none, send 0xA5 with one stop bit -> one rx_dv pulse; rx_data=0xA5, all flags 0, busy low afterwards.
2. parity_mode=1, send 0x07 with parity bit 1 -> parity_err=0. Same data with parity bit 0 -> parity_err=1 and rx_data=0x07. Repeat with parity_mode=2 and check inverted results.
3. Glitch low for 4 ticks on an idle line -> no rx_dv; busy returns low by tick 9; the next valid 0x3C frame is received correctly.
4. STOP_BITS=2, second stop bit forced 0 on frame 0x55 -> rx_data=0x55, frame_err=1, rx_break=0. Receiver waits for rx high before the next frame.
5. Hold rx low for 2 frame times -> exactly one rx_dv with rx_break=1, frame_err=1, rx_data=0. No further strobe until rx returns high.
6. Two back-to-back frames 0x01 and 0xFE at +2% baud skew, then rst_n asserted mid-frame on a third -> two correct strobes, no strobe for the aborted frame, all outputs 0 after reset.
